mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register and writeback formatter for the MIPS32 core; sits directly upstream of register_file.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mem_wb_stage_load_extend.sv | 55 +++++
 rtl/mem_wb_stage.sv | 120 ++++++++++++
 tb/tb_mem_wb_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the MIPS32 MEM/WB writeback path.
//   WB_*   : writeback source select (in_wbSel). 2'b11 is reserved and behaves as ALU.
//   LD_*   : load type (in_loadType). Unlisted codes behave as LD_W.
//   REG_ZERO : index of the hard-wired zero register.
package mips_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend: combinational little-endian load formatter.
// Ports:
//   memData  [31:0] in  raw data-memory word
//   loadType [2:0]  in  LD_* encoding (unknown codes act as LD_W)
//   addrLow  [1:0]  in  effective address bits [1:0]
//   data     [31:0] out extended load value (raw word when misaligned)
//   misalign        out access is not naturally aligned for its size
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] memData,
  input  logic [2:0]  loadType,
  input  logic [1:0]  addrLow,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane select: address 0 picks the least-significant lane.
  always_comb begin
    w_byte = 8'h00;
    case (addrLow)
      2'd0: w_byte = memData[7:0];
      2'd1: w_byte = memData[15:8];
      2'd2: w_byte = memData[23:16];
      default: w_byte = memData[31:24];
    endcase
    w_half = addrLow[1] ? memData[31:16] : memData[15:0];
  end

  always_comb begin
    data     = memData;
    misalign = 1'b0;
    case (loadType)
      LD_B:  data = {{24{w_byte[7]}}, w_byte};
      LD_BU: data = {24'h000000, w_byte};
      LD_H: begin
        misalign = addrLow[0];
        data     = addrLow[0] ? memData : {{16{w_half[15]}}, w_half};
      end
      LD_HU: begin
        misalign = addrLow[0];
        data     = addrLow[0] ? memData : {16'h0000, w_half};
      end
      default: begin
        // LW and unrecognised codes: word passes through untouched.
        misalign = (addrLow != 2'd0);
        data     = memData;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback formatter feeding register_file.
// Optional feature macro: MEM_WB_RETIRE_CNT_EN adds output retire_count[31:0].
// Ports:
//   clock, reset (sync, active-high), stall (hold), flush (bubble)
//   in_valid, in_regWrite, in_writeReg, in_wbSel, in_loadType, in_addrLow,
//   in_aluResult, in_memData, in_pcPlus4       : MEM-stage results
//   writeReg, writeData, regWrite               : registered register-file write port
//   wb_valid                                    : WB slot holds a real instruction
//   wb_misalign                                 : held load was misaligned (write suppressed)
//   retire_count (MEM_WB_RETIRE_CNT_EN only)    : count of valid captures, wraps
// Handshake: no valid/ready; stall holds every register, flush clears the
// valid/write/misalign flags while keeping writeReg/writeData for forwarding taps.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regWrite,
  input  logic [REG_AW-1:0] in_writeReg,
  input  logic [1:0]        in_wbSel,
  input  logic [2:0]        in_loadType,
  input  logic [1:0]        in_addrLow,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_memData,
  input  logic [DATA_W-1:0] in_pcPlus4,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              wb_valid,
  output logic              wb_misalign
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  logic [DATA_W-1:0] w_load_data;
  logic              w_load_misalign;
  logic              w_misalign;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_reg_write;

  logic [REG_AW-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_reg_write;
  logic              r_wb_valid;
  logic              r_wb_misalign;

  load_extend u_load_extend (
    .memData  (in_memData),
    .loadType (in_loadType),
    .addrLow  (in_addrLow),
    .data     (w_load_data),
    .misalign (w_load_misalign)
  );

  // Alignment only matters when the load result is actually the writeback source.
  assign w_misalign = (in_wbSel == WB_MEM) && w_load_misalign;

  always_comb begin
    w_wb_data = in_aluResult;
    case (in_wbSel)
      WB_MEM:  w_wb_data = w_load_data;
      WB_LINK: w_wb_data = in_pcPlus4 + DATA_W'(4);
      default: w_wb_data = in_aluResult;
    endcase
  end

  assign w_reg_write = in_valid && in_regWrite &&
                       (in_writeReg != REG_AW'(REG_ZERO)) && !w_misalign;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_reg   <= '0;
      r_write_data  <= '0;
      r_reg_write   <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_misalign <= 1'b0;
    end else if (flush) begin
      r_reg_write   <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_misalign <= 1'b0;
    end else if (!stall) begin
      r_write_reg   <= in_writeReg;
      r_write_data  <= w_wb_data;
      r_reg_write   <= w_reg_write;
      r_wb_valid    <= in_valid;
      // A bubble is not a load, so it never reports misalignment.
      r_wb_misalign <= in_valid && w_misalign;
    end
  end

  assign writeReg    = r_write_reg;
  assign writeData   = r_write_data;
  assign regWrite    = r_reg_write;
  assign wb_valid    = r_wb_valid;
  assign wb_misalign = r_wb_misalign;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] r_retire_count;

  // Misaligned loads and $0 writes still retire; natural wrap at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retire_count <= 32'd0;
    end else if (!flush && !stall && in_valid) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_regWrite;
  logic [4:0]  in_writeReg;
  logic [1:0]  in_wbSel;
  logic [2:0]  in_loadType;
  logic [1:0]  in_addrLow;
  logic [31:0] in_aluResult, in_memData, in_pcPlus4;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite, wb_valid, wb_misalign;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state (what the WB slot should hold).
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_rw, m_valid, m_mis, m_mis_known;
  logic [31:0] m_cnt;

  mem_wb_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regWrite(in_regWrite), .in_writeReg(in_writeReg),
    .in_wbSel(in_wbSel), .in_loadType(in_loadType), .in_addrLow(in_addrLow),
    .in_aluResult(in_aluResult), .in_memData(in_memData), .in_pcPlus4(in_pcPlus4),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .wb_valid(wb_valid), .wb_misalign(wb_misalign)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Writeback value from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [2:0] lt,
                                         input logic [1:0] a, input logic [31:0] alu,
                                         input logic [31:0] mem, input logic [31:0] pc,
                                         output logic mis);
    longint unsigned b, h;
    logic [31:0] ld;
    logic lmis;
    lmis = 1'b0;
    ld = mem;
    if (lt == 3 || lt == 4) begin
      b = (longint'(mem) >> (8 * a)) % 256;
      ld = 32'(b);
      if (lt == 3 && b >= 128) ld = 32'(b) + 32'hFFFF_FF00;
    end else if (lt == 1 || lt == 2) begin
      if (a % 2 == 1) lmis = 1'b1;
      else begin
        h = (longint'(mem) >> (16 * (a / 2))) % 65536;
        ld = 32'(h);
        if (lt == 1 && h >= 32768) ld = 32'(h) + 32'hFFFF_0000;
      end
    end else begin
      lmis = (a != 0);
    end
    mis = 1'b0;
    if (sel == 2'd1) begin
      mis = lmis;
      return ld;
    end else if (sel == 2'd2) return pc + 32'd4;
    return alu;
  endfunction

  // Driver tasks
  task automatic set_in(input logic v, input logic rw, input logic [4:0] r,
                        input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] a,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    in_valid = v; in_regWrite = rw; in_writeReg = r; in_wbSel = sel;
    in_loadType = lt; in_addrLow = a; in_aluResult = alu; in_memData = mem; in_pcPlus4 = pc;
  endtask

  // Advance one edge, update the model, then compare every output.
  task automatic tick(input string tag);
    logic mis;
    logic [31:0] d;
    d = ref_wb(in_wbSel, in_loadType, in_addrLow, in_aluResult, in_memData, in_pcPlus4, mis);
    if (reset) begin
      m_reg = 0; m_data = 0; m_rw = 0; m_valid = 0; m_mis = 0; m_mis_known = 1; m_cnt = 0;
    end else if (flush) begin
      m_rw = 0; m_valid = 0; m_mis = 0; m_mis_known = 1;
    end else if (!stall) begin
      m_reg = in_writeReg; m_data = d; m_valid = in_valid;
      m_rw = in_valid && in_regWrite && (in_writeReg != 0) && !mis;
      m_mis = mis; m_mis_known = in_valid;
      if (in_valid) m_cnt = m_cnt + 1;
    end
    @(posedge clock); #1;
    chk({tag, ".writeReg"},  32'(writeReg), 32'(m_reg));
    chk({tag, ".writeData"}, writeData, m_data);
    chk({tag, ".regWrite"},  32'(regWrite), 32'(m_rw));
    chk({tag, ".wb_valid"},  32'(wb_valid), 32'(m_valid));
    if (m_mis_known) chk({tag, ".wb_misalign"}, 32'(wb_misalign), 32'(m_mis));
`ifdef MEM_WB_RETIRE_CNT_EN
    chk({tag, ".retire_count"}, retire_count, m_cnt);
`endif
  endtask

  initial begin
    m_cnt = 0; m_mis_known = 0;
    reset = 1; stall = 0; flush = 0;
    // Reset held two cycles with live inputs.
    set_in(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h1111_2222, 32'h3333_4444, 32'h0040_0000);
    tick("reset0");
    tick("reset1");
    chk("reset.writeData_zero", writeData, 32'h0);
    reset = 0;
    tick("first_capture");
    chk("first_capture.data", writeData, 32'h1111_2222);

    // LB / LBU
    set_in(1, 1, 5'd5, 2'd1, 3'd3, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0);
    tick("lb");
    chk("lb.const", writeData, 32'hFFFF_FFFF);
    set_in(1, 1, 5'd5, 2'd1, 3'd4, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0);
    tick("lbu");
    chk("lbu.const", writeData, 32'h0000_00FF);
    chk("lbu.regWrite", 32'(regWrite), 32'd1);

    // LH misaligned, then aligned upper half
    set_in(1, 1, 5'd6, 2'd1, 3'd1, 2'd1, 32'h0, 32'h1234_5678, 32'h0);
    tick("lh_mis");
    chk("lh_mis.flag", 32'(wb_misalign), 32'd1);
    chk("lh_mis.data", writeData, 32'h1234_5678);
    set_in(1, 1, 5'd6, 2'd1, 3'd1, 2'd2, 32'h0, 32'h1234_5678, 32'h0);
    tick("lh_hi");
    chk("lh_hi.const", writeData, 32'h0000_1234);

    // $0 destination and LINK
    set_in(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0000_DEAD, 32'h0, 32'h0);
    tick("reg0");
    chk("reg0.regWrite", 32'(regWrite), 32'd0);
    chk("reg0.valid", 32'(wb_valid), 32'd1);
    set_in(1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0008);
    tick("link");
    chk("link.const", writeData, 32'h0040_000C);

    // Stall holds, flush beats stall
    set_in(1, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'd7, 32'h0, 32'h0);
    tick("cap7");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 5'(i + 10), 2'd0, 3'd0, 2'd0, $urandom, $urandom, $urandom);
      tick("stall");
    end
    chk("stall.data", writeData, 32'd7);
    chk("stall.reg", 32'(writeReg), 32'd3);
    flush = 1;
    tick("flush_stall");
    chk("flush_stall.regWrite", 32'(regWrite), 32'd0);
    chk("flush_stall.data_held", writeData, 32'd7);
    stall = 0; flush = 0;

    // Reset during stall
    stall = 1; reset = 1;
    tick("reset_in_stall");
    stall = 0; reset = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      set_in(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, (i == 7) ? 32'hFFFF_FFFC : $urandom);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      reset = ($urandom_range(0, 99) < 2);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
